// File: rtl/seg_pkg.sv
// seg_pkg: segment bit positions, hex-to-segment table and handshake state type
package seg_pkg;
    localparam int SEG_A  = 7;
    localparam int SEG_B  = 6;
    localparam int SEG_C  = 5;
    localparam int SEG_D  = 4;
    localparam int SEG_E  = 3;
    localparam int SEG_F  = 2;
    localparam int SEG_G  = 1;
    localparam int SEG_DP = 0;
    localparam logic [7:0] HEX_SEG [16] = '{
        8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
        8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E
    };
    typedef enum logic {IDLE, PENDING} state_t;
endpackage

// File: rtl/hex_seg_driver_if.sv
// hex_seg_driver_if: producer-to-display word handshake
interface hex_seg_driver_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_value;
    logic [7:0]  in_dp;
    logic [7:0]  in_blink;
    logic        in_blank_lz;
    modport master(output in_valid, in_value, in_dp, in_blink, in_blank_lz, input in_ready);
    modport slave(input in_valid, in_value, in_dp, in_blink, in_blank_lz, output in_ready);
endinterface

// File: rtl/hex7_decode.sv
// hex7_decode: one digit's lit segment pattern from nibble, dp and dark
module hex7_decode
    import seg_pkg::*;
(
    input  logic [3:0] nib,
    input  logic       dp,
    input  logic       dark,
    output logic [7:0] lit
);
    always_comb begin
        lit = dark ? 8'h00 : HEX_SEG[nib];
        lit[SEG_DP] = lit[SEG_DP] | dp;
    end
endmodule

// File: rtl/hex_seg_driver.sv
// hex_seg_driver: double-buffered 8-digit hex display with blink and leading-zero blanking
module hex_seg_driver
    import seg_pkg::*;
#(
    parameter int unsigned CLK_NUM      = 5000000,
    parameter int unsigned BLINK_FRAMES = 4
) (
    input  logic             clk,
    input  logic             rst,
    hex_seg_driver_if.slave  bus,
    output logic [7:0]       o_seg0,
    output logic [7:0]       o_seg1,
    output logic [7:0]       o_seg2,
    output logic [7:0]       o_seg3,
    output logic [7:0]       o_seg4,
    output logic [7:0]       o_seg5,
    output logic [7:0]       o_seg6,
    output logic [7:0]       o_seg7,
    output logic             frame_tick
);
    logic [31:0] count, bcnt, sh_value, act_value;
    logic [7:0]  sh_dp, sh_blink, act_dp, act_blink;
    logic        sh_blz, act_blz, blink_phase, accept, commit;
    state_t      state, state_nx;
    logic [7:0]  lit [8];
    logic [7:0]  seg_q [8];
    assign frame_tick = count == CLK_NUM;
    assign bus.in_ready = state == IDLE;
    assign accept = state == IDLE && bus.in_valid;
    assign commit = state == PENDING && frame_tick;
    always_ff @(posedge clk)
        count <= (rst || frame_tick) ? 32'd0 : count + 32'd1;
    always_ff @(posedge clk)
        state <= rst ? IDLE : state_nx;
    always_comb begin
        state_nx = state;
        state_nx = (state == IDLE) ? (bus.in_valid ? PENDING : IDLE) : (frame_tick ? IDLE : PENDING);
    end
    // A word accepted in a tick cycle only reaches the shadow; commit needs PENDING.
    always_ff @(posedge clk) begin
        if (rst) begin
            {sh_value, sh_dp, sh_blink, sh_blz} <= '0;
            {act_value, act_dp, act_blink, act_blz} <= '0;
        end else begin
            if (accept)
                {sh_value, sh_dp, sh_blink, sh_blz} <= {bus.in_value, bus.in_dp, bus.in_blink, bus.in_blank_lz};
            if (commit)
                {act_value, act_dp, act_blink, act_blz} <= {sh_value, sh_dp, sh_blink, sh_blz};
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            bcnt <= 32'd0;
            blink_phase <= 1'b0;
        end else if (frame_tick) begin
            bcnt <= (bcnt == BLINK_FRAMES - 1) ? 32'd0 : bcnt + 32'd1;
            blink_phase <= (bcnt == BLINK_FRAMES - 1) ? ~blink_phase : blink_phase;
        end
    end
    // Blink darkens the whole digit; a leading-zero blank keeps its dp.
    for (genvar i = 0; i < 8; i++) begin : g_dig
        logic bdark, zdark;
        assign bdark = blink_phase & act_blink[i];
        assign zdark = (i != 0) && act_blz && ((act_value >> (4 * i)) == 32'd0);
        hex7_decode u_dec (
            .nib (act_value[4*i +: 4]),
            .dp  (act_dp[i] & ~bdark),
            .dark(bdark | zdark),
            .lit (lit[i])
        );
    end
    always_ff @(posedge clk)
        for (int k = 0; k < 8; k++)
            seg_q[k] <= rst ? 8'h03 : ~lit[k];
    assign {o_seg7, o_seg6, o_seg5, o_seg4} = {seg_q[7], seg_q[6], seg_q[5], seg_q[4]};
    assign {o_seg3, o_seg2, o_seg1, o_seg0} = {seg_q[3], seg_q[2], seg_q[1], seg_q[0]};
endmodule

// File: tb/tb_hex_seg_driver.sv
// tb_hex_seg_driver: randomized scenarios checked against a digit-shape display model
module tb_hex_seg_driver;
    import seg_pkg::*;
    localparam int CN = 3, BF = 2, P = CN + 1;
    logic clk = 1'b0, rst = 1'b1;
    wire        frame_tick;
    wire [7:0]  seg [8];
    int total = 0, bad = 0, cyc = 0;
    logic [31:0] cur_v = '0, pend_v = '0;
    logic [7:0]  cur_dp = '0, cur_bl = '0, pend_dp = '0, pend_bl = '0;
    logic        cur_blz = 1'b0, pend_blz = 1'b0;
    string shapes [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                           "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};
    hex_seg_driver_if ifc();
    hex_seg_driver #(.CLK_NUM(CN), .BLINK_FRAMES(BF)) dut (
        .clk(clk), .rst(rst), .bus(ifc),
        .o_seg0(seg[0]), .o_seg1(seg[1]), .o_seg2(seg[2]), .o_seg3(seg[3]),
        .o_seg4(seg[4]), .o_seg5(seg[5]), .o_seg6(seg[6]), .o_seg7(seg[7]),
        .frame_tick(frame_tick)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= rst ? 0 : cyc + 1;
    // Expected pins of digit i in cycle c: blink phase from ticks seen up to c-2.
    function automatic logic [7:0] exp_seg(input int i, input int c);
        logic [7:0] lit = 8'h00;
        int n = (c < 2) ? 0 : (c - 1) / P;
        logic bdark = ((n / BF) % 2 == 1) && cur_bl[i];
        logic zdark = cur_blz && i > 0 && ((cur_v >> (4 * i)) == 32'd0);
        string s = shapes[cur_v[4*i +: 4]];
        if (!bdark && !zdark)
            for (int j = 0; j < s.len(); j++)
                case (s[j])
                    "a": lit[SEG_A] = 1'b1;
                    "b": lit[SEG_B] = 1'b1;
                    "c": lit[SEG_C] = 1'b1;
                    "d": lit[SEG_D] = 1'b1;
                    "e": lit[SEG_E] = 1'b1;
                    "f": lit[SEG_F] = 1'b1;
                    default: lit[SEG_G] = 1'b1;
                endcase
        if (!bdark && cur_dp[i]) lit[SEG_DP] = 1'b1;
        return ~lit;
    endfunction
    function automatic int next_tick(input int acc);
        int c = acc + 1;
        while (c % P != P - 1) c++;
        return c;
    endfunction
    task automatic wait_cyc(input int t);
        for (int k = 0; k < 1000 && cyc != t; k++) @(negedge clk);
        if (cyc != t) begin
            total++; bad++;
            $display("FAIL wait_cyc got cycle %0d want %0d", cyc, t);
        end
    endtask
    task automatic send(input logic [31:0] v, input logic [7:0] dp, input logic [7:0] bl,
                        input logic blz, output int acc);
        {ifc.in_value, ifc.in_dp, ifc.in_blink, ifc.in_blank_lz} = {v, dp, bl, blz};
        {pend_v, pend_dp, pend_bl, pend_blz} = {v, dp, bl, blz};
        ifc.in_valid = 1'b1;
        acc = -1;
        for (int k = 0; k < 40 && acc < 0; k++) begin
            if (ifc.in_ready === 1'b1) acc = cyc;
            @(negedge clk);
        end
        ifc.in_valid = 1'b0;
        if (acc < 0) begin
            total++; bad++;
            $display("FAIL send timeout value=%h", v);
        end
    endtask
    task automatic commit(input int acc);
        wait_cyc(next_tick(acc) + 2);
        {cur_v, cur_dp, cur_bl, cur_blz} = {pend_v, pend_dp, pend_bl, pend_blz};
    endtask
    task automatic do_reset();
        rst = 1'b1;
        ifc.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        {cur_v, cur_dp, cur_bl, cur_blz} = '0;
    endtask
    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            total++;
            if (seg[i] !== 8'h03) begin bad++; $display("FAIL reset seg%0d got %h want 03", i, seg[i]); end
        end
        total++;
        if (ifc.in_ready !== 1'b1) begin bad++; $display("FAIL reset in_ready got %b want 1", ifc.in_ready); end
        for (int k = 0; k < 12; k++) begin
            total++;
            if (frame_tick !== 1'(cyc % P == P - 1)) begin
                bad++; $display("FAIL frame_tick cycle %0d got %b want %b", cyc, frame_tick, cyc % P == P - 1);
            end
            @(negedge clk);
        end
    endtask
    task automatic test_write();
        int acc, t;
        send(32'h89ABCDEF, 8'h01, 8'h00, 1'b0, acc);
        if (acc < 0) return;
        t = next_tick(acc);
        while (cyc <= t) begin
            total++;
            if (ifc.in_ready !== 1'b0) begin bad++; $display("FAIL pending in_ready cycle %0d got %b want 0", cyc, ifc.in_ready); end
            @(negedge clk);
        end
        total++;
        if (ifc.in_ready !== 1'b1) begin bad++; $display("FAIL after tick in_ready got %b want 1", ifc.in_ready); end
        commit(acc);
        total += 2;
        if (seg[0] !== 8'h70) begin bad++; $display("FAIL write seg0 got %h want 70", seg[0]); end
        if (seg[7] !== 8'h01) begin bad++; $display("FAIL write seg7 got %h want 01", seg[7]); end
        for (int i = 0; i < 8; i++) begin
            total++;
            if (seg[i] !== exp_seg(i, cyc)) begin bad++; $display("FAIL write model seg%0d got %h want %h", i, seg[i], exp_seg(i, cyc)); end
        end
    endtask
    task automatic test_back_to_back();
        int acc_a, acc_b, ta;
        send($urandom, 8'($urandom), 8'h00, 1'b0, acc_a);
        ta = next_tick(acc_a);
        send(32'h1, 8'h00, 8'h00, 1'b0, acc_b);
        total++;
        if (acc_b != ta + 1) begin bad++; $display("FAIL backpressure accept cycle got %0d want %0d", acc_b, ta + 1); end
        commit(acc_b);
        for (int i = 0; i < 8; i++) begin
            total++;
            if (seg[i] !== exp_seg(i, cyc)) begin bad++; $display("FAIL b2b seg%0d got %h want %h", i, seg[i], exp_seg(i, cyc)); end
        end
    endtask
    task automatic test_leading_zero();
        int acc;
        send(32'h00000120, 8'h00, 8'h00, 1'b1, acc);
        commit(acc);
        for (int i = 3; i < 8; i++) begin
            total++;
            if (seg[i] !== 8'hFF) begin bad++; $display("FAIL lz seg%0d got %h want FF", i, seg[i]); end
        end
        total += 3;
        if (seg[2] !== 8'h9F) begin bad++; $display("FAIL lz seg2 got %h want 9F", seg[2]); end
        if (seg[1] !== 8'h25) begin bad++; $display("FAIL lz seg1 got %h want 25", seg[1]); end
        if (seg[0] !== 8'h03) begin bad++; $display("FAIL lz seg0 got %h want 03", seg[0]); end
        send(32'h0, 8'h00, 8'h00, 1'b1, acc);
        commit(acc);
        for (int i = 0; i < 8; i++) begin
            total++;
            if (seg[i] !== (i == 0 ? 8'h03 : 8'hFF)) begin bad++; $display("FAIL lz zero seg%0d got %h want %h", i, seg[i], i == 0 ? 8'h03 : 8'hFF); end
        end
        send(32'h5, 8'h80, 8'h00, 1'b1, acc);
        commit(acc);
        total++;
        if (seg[7] !== 8'hFE) begin bad++; $display("FAIL lz dp seg7 got %h want FE", seg[7]); end
    endtask
    task automatic test_blink();
        int acc;
        bit saw_dark = 0, saw_lit = 0;
        send($urandom | 32'h8000_0000, 8'($urandom), 8'h80, 1'b0, acc);
        commit(acc);
        for (int k = 0; k < 24; k++) begin
            total += 2;
            if (seg[7] !== exp_seg(7, cyc)) begin bad++; $display("FAIL blink seg7 cycle %0d got %h want %h", cyc, seg[7], exp_seg(7, cyc)); end
            if (seg[0] !== exp_seg(0, cyc)) begin bad++; $display("FAIL blink seg0 cycle %0d got %h want %h", cyc, seg[0], exp_seg(0, cyc)); end
            if (seg[7] === 8'hFF) saw_dark = 1;
            else saw_lit = 1;
            @(negedge clk);
        end
        total++;
        if (!(saw_dark && saw_lit)) begin bad++; $display("FAIL blink alternation got dark=%0d lit=%0d want 1 1", saw_dark, saw_lit); end
    endtask
    task automatic test_same_cycle_tick();
        int acc;
        for (int k = 0; k < 2 * P && cyc % P != P - 1; k++) @(negedge clk);
        send($urandom, 8'($urandom), 8'h00, 1'b0, acc);
        total++;
        if (acc % P != P - 1) begin bad++; $display("FAIL tick handshake cycle got %0d want a tick cycle", acc); end
        wait_cyc(acc + 2);
        for (int i = 0; i < 8; i++) begin
            total++;
            if (seg[i] !== exp_seg(i, cyc)) begin bad++; $display("FAIL tick hs old seg%0d got %h want %h", i, seg[i], exp_seg(i, cyc)); end
        end
        commit(acc);
        for (int i = 0; i < 8; i++) begin
            total++;
            if (seg[i] !== exp_seg(i, cyc)) begin bad++; $display("FAIL tick hs new seg%0d got %h want %h", i, seg[i], exp_seg(i, cyc)); end
        end
    endtask
    task automatic test_random();
        int acc;
        for (int r = 0; r < 8; r++) begin
            send($urandom >> (4 * $urandom_range(0, 7)), 8'($urandom), 8'($urandom), 1'($urandom), acc);
            commit(acc);
            repeat ($urandom_range(0, 6)) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                total++;
                if (seg[i] !== exp_seg(i, cyc)) begin bad++; $display("FAIL random %0d seg%0d got %h want %h", r, i, seg[i], exp_seg(i, cyc)); end
            end
        end
    endtask
    task automatic test_reset_pending();
        int acc;
        send($urandom | 32'h1111_1111, 8'hFF, 8'h00, 1'b0, acc);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        {cur_v, cur_dp, cur_bl, cur_blz} = '0;
        repeat (2) @(negedge clk);
        total++;
        if (ifc.in_ready !== 1'b1) begin bad++; $display("FAIL rst pending in_ready got %b want 1", ifc.in_ready); end
        for (int i = 0; i < 8; i++) begin
            total++;
            if (seg[i] !== 8'h03) begin bad++; $display("FAIL rst pending seg%0d got %h want 03", i, seg[i]); end
        end
        wait_cyc(10);
        for (int i = 0; i < 8; i++) begin
            total++;
            if (seg[i] !== 8'h03) begin bad++; $display("FAIL rst discard seg%0d got %h want 03", i, seg[i]); end
        end
    endtask
    initial begin
        ifc.in_valid = 1'b0;
        {ifc.in_value, ifc.in_dp, ifc.in_blink, ifc.in_blank_lz} = '0;
        test_reset();
        test_write();
        test_back_to_back();
        test_leading_zero();
        test_blink();
        test_same_cycle_tick();
        test_random();
        test_reset_pending();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/hex_seg_driver.md
# hex_seg_driver

Upstream feeder for the board's eight 7-segment digits: accepts a 32-bit hex value plus per-digit decimal-point and blink masks over a valid/ready handshake, double-buffers it, and drives eight active-low segment buses. New values are committed only at frame boundaries, so a display never shows a half-updated word. Blinking and leading-zero blanking are handled here, so producers such as counters and the CPU MMIO bridge only write values.

## Interface
- CLK_NUM, 5000000: frame period is CLK_NUM+1 clock cycles; the frame tick fires when the frame counter equals CLK_NUM.
- BLINK_FRAMES, 4: number of frame ticks per blink half-period; minimum 1.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  producer offers a new display word.
- in_ready  out  1  block can accept a word.
- in_value  in  32  digit i is in_value[4i+3:4i]; digit 0 is rightmost.
- in_dp  in  8  bit i lights the decimal point of digit i.
- in_blink  in  8  bit i makes digit i blink.
- in_blank_lz  in  1  enables leading-zero blanking.
- o_seg0..o_seg7  out  8 each  active-low segments for digit i. Bit order: bit7=a, bit6=b, bit5=c, bit4=d, bit3=e, bit2=f, bit1=g, bit0=dp.
- frame_tick  out  1  one-cycle pulse at each frame boundary.

## Operation
- Frame counter (32 bit):
  - Counts 0..CLK_NUM, then wraps to 0.
  - frame_tick = (count == CLK_NUM), combinational from the counter.
- Handshake FSM with two states, IDLE and PENDING:
  - IDLE: in_ready=1. When in_valid is high, latch value, dp, blink and blank_lz into the shadow register and move to PENDING.
  - PENDING: in_ready=0. On frame_tick, copy shadow to active and return to IDLE.
  - If a handshake and frame_tick occur in the same cycle in IDLE, the word goes to shadow only. It is committed at the next tick.
  - in_valid while in PENDING is ignored. The producer must hold its word.
- Blink:
  - A tick counter runs 0..BLINK_FRAMES-1 and advances on frame_tick.
  - At wrap, blink_phase toggles.
  - When blink_phase=1, digits with their active blink bit set are fully dark, including dp.
- Leading-zero blanking (when the active blank_lz bit is set):
  - Digit i (i≥1) is dark when its nibble and all higher nibbles are 0.
  - Digit 0 is never blanked.
  - The dp of a blanked digit still follows in_dp.
- Decode (lit=1, then inverted on output):
  - 0=FC, 1=60, 2=DA, 3=F2, 4=66, 5=B6, 6=BE, 7=E0
  - 8=FE, 9=F6, A=EE, b=3E, C=9C, d=7A, E=9E, F=8E
  - A dark digit is 8'h00 lit, which is 8'hFF on the output.
  - dp ORs into bit0.
- Reset values:
  - count=0, FSM=IDLE, in_ready=1, blink_phase=0, blink counter=0.
  - Shadow and active registers all 0.
  - o_seg0..7 = 8'h03 (all digits show "0", dp off).
  - frame_tick=0.
- Reset applied mid-PENDING discards the shadow word. Reset does not wait for a tick.

## Timing
- The active registers load at the end of the tick cycle T.
- o_seg* are registered and reflect the new active state from cycle T+2.
- A blink_phase toggle at tick T is visible on o_seg* from cycle T+2.
- Worst-case latency from handshake to display is CLK_NUM+3 cycles.
- in_ready deasserts in the cycle after acceptance. It reasserts in the cycle after the committing tick.
- Single-cycle-per-word throughput is not supported: at most one word is accepted per frame.

## Structure
- Shared package seg_pkg holds:
  - the 16-entry hex-to-segment constant table,
  - segment bit-index constants (SEG_A..SEG_G, SEG_DP),
  - the FSM state typedef (IDLE, PENDING).
- One sub-module, hex7_decode: nibble plus dp plus dark in, 8-bit lit pattern out. It is combinational and instanced once per digit.
- The counters, FSM, blanking logic and output registers live in the top module.

## Test plan
All scenarios run with CLK_NUM=3 and BLINK_FRAMES=2.
- Reset: hold rst for 2 cycles -> all o_seg = 8'h03, in_ready=1, and frame_tick pulses every 4th cycle after release.
- Write: in_value=32'h89ABCDEF with in_dp=8'h01 -> after the next tick+2, o_seg0 = ~8'h8F = 8'h70, o_seg7 = ~8'hFE = 8'h01, and in_ready is 0 throughout PENDING.
- Back-pressure: hold in_valid with a second word 32'h1 while PENDING -> the second word is not accepted until in_ready returns. It then displays one frame later.
- Leading zeros: in_value=32'h00000120 with blank_lz=1 -> o_seg3..7 = 8'hFF, o_seg2 = 8'h9F, o_seg0 = 8'h03. A value of 0 shows only digit 0.
- Blink: in_blink=8'h80 -> o_seg7 alternates between its digit pattern and 8'hFF, switching every 2 ticks (8 cycles); other digits are steady.
- Simultaneous events and reset: a handshake exactly in the tick cycle is committed at the following tick. Asserting rst during PENDING returns all o_seg to 8'h03 two cycles later and in_ready to 1.
